// File: rtl/ntt_pkg.sv
// Shared modular-arithmetic helpers for the NTT/INTT processing elements.
// All helpers assume their operands are already reduced, i.e. < q, and q is odd.
package ntt_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] coef_t;

    function automatic coef_t mod_add(input coef_t a, input coef_t b, input coef_t q);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q}) begin
            s = s - {1'b0, q};
        end
        return s[DATA_W-1:0];
    endfunction

    // The top bit of the widened difference is the borrow.
    function automatic coef_t mod_sub(input coef_t a, input coef_t b, input coef_t q);
        logic [DATA_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[DATA_W]) begin
            d = d + {1'b0, q};
        end
        return d[DATA_W-1:0];
    endfunction

    // Multiplying by 2^-1 mod q: an odd x becomes even once q is added.
    function automatic coef_t mod_half(input coef_t x, input coef_t q);
        logic [DATA_W:0] t;
        t = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
        return t[DATA_W:1];
    endfunction

endpackage

// File: rtl/ModMult.sv
// Modular multiplier p = a*b mod q with a fixed input-to-output latency of LAT cycles.
// The reduction is an MSB-first shift-and-add, so no double-width product is ever formed.
module ModMult
    import ntt_pkg::*;
#(
    parameter int LAT = 13
) (
    input  logic  clk,
    input  logic  reset,
    input  coef_t a,
    input  coef_t b,
    input  coef_t q,
    output coef_t p
);

    function automatic coef_t mod_mul(input coef_t x, input coef_t y, input coef_t m);
        logic [DATA_W:0] r;
        r = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            r = r << 1;
            if (r >= {1'b0, m}) begin
                r = r - {1'b0, m};
            end
            if (y[i]) begin
                r = r + {1'b0, x};
            end
            if (r >= {1'b0, m}) begin
                r = r - {1'b0, m};
            end
        end
        return r[DATA_W-1:0];
    endfunction

    coef_t product;
    coef_t stage [LAT];

    assign product = mod_mul(a, b, q);

    // The trailing stages give synthesis registers to retime into the reduction logic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= product;
            for (int i = 1; i < LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign p = stage[LAT-1];

endmodule

// File: rtl/shift_reg.sv
// Fixed-depth delay line: q presents d delayed by exactly DEPTH cycles.
module shift_reg #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign q = taps[DEPTH-1];

endmodule

// File: rtl/intt_pe.sv
// Gentleman-Sande inverse-NTT butterfly: takes serial (a, b) pairs and emits (a+b)/2 and
// ((a-b)/2)*w^-1 mod q back-to-back, even result first, so n^-1 is folded into every stage.
module intt_pe
    import ntt_pkg::*;
#(
    parameter int MULT_LAT = 13
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  start,
    input  coef_t q,
    input  logic  in_valid,
    input  coef_t data_i,
    input  coef_t twiddle_i,
    output coef_t ntt_o,
    output logic  out_valid,
    output logic  out_odd,
    output logic  busy
);

    logic              phase;
    logic              cur_phase;
    logic              launch;
    coef_t             a_hold;
    coef_t             half_sum;
    coef_t             half_diff;
    coef_t             twiddle;
    logic [MULT_LAT:0] valid_pipe;
    coef_t             sum_dly;
    coef_t             product;
    coef_t             skid;
    logic              skid_valid;

    // A start pulse realigns the pair phase before this cycle's sample is classified.
    assign cur_phase = phase & ~start;
    assign launch    = in_valid & cur_phase;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase  <= 1'b0;
            a_hold <= '0;
        end else begin
            phase <= in_valid ? ~cur_phase : cur_phase;
            if (in_valid && !cur_phase) begin
                a_hold <= data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            half_sum   <= '0;
            half_diff  <= '0;
            twiddle    <= '0;
            valid_pipe <= '0;
        end else begin
            if (launch) begin
                half_sum  <= mod_half(mod_add(a_hold, data_i, q), q);
                half_diff <= mod_half(mod_sub(a_hold, data_i, q), q);
                twiddle   <= twiddle_i;
            end
            valid_pipe <= {valid_pipe[MULT_LAT-1:0], launch};
        end
    end

    ModMult #(
        .LAT (MULT_LAT)
    ) u_mult (
        .clk   (clk),
        .reset (reset),
        .a     (half_diff),
        .b     (twiddle),
        .q     (q),
        .p     (product)
    );

    shift_reg #(
        .WIDTH (DATA_W),
        .DEPTH (MULT_LAT)
    ) u_sum_dly (
        .clk   (clk),
        .reset (reset),
        .d     (half_sum),
        .q     (sum_dly)
    );

    // Pairs arrive at most every other cycle, so the skid slot is always free for the odd result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ntt_o      <= '0;
            out_valid  <= 1'b0;
            out_odd    <= 1'b0;
            skid       <= '0;
            skid_valid <= 1'b0;
        end else if (valid_pipe[MULT_LAT]) begin
            ntt_o      <= sum_dly;
            out_valid  <= 1'b1;
            out_odd    <= 1'b0;
            skid       <= product;
            skid_valid <= 1'b1;
        end else if (skid_valid) begin
            ntt_o      <= skid;
            out_valid  <= 1'b1;
            out_odd    <= 1'b1;
            skid_valid <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
        end
    end

    assign busy = phase | (|valid_pipe) | skid_valid;

endmodule

// File: tb/tb_intt_pe.sv
// Scoreboard bench for intt_pe with q=17: stimulus pushes hand-computed results, a monitor
// pops one entry per out_valid cycle and checks value, even/odd slot and arrival cycle.
module tb_intt_pe;
    import ntt_pkg::*;

    localparam int LAT = 13;

    typedef struct {
        coef_t val;
        logic  odd;
        int    when;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    logic  start = 1'b0;
    logic  in_valid = 1'b0;
    coef_t q = 16'd17;
    coef_t data_i = '0;
    coef_t twiddle_i = '0;
    coef_t ntt_o;
    logic  out_valid;
    logic  out_odd;
    logic  busy;

    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    int    k_last = 0;
    exp_t  sbq [$];
    exp_t  mon_e;

    intt_pe #(
        .MULT_LAT (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .q         (q),
        .in_valid  (in_valid),
        .data_i    (data_i),
        .twiddle_i (twiddle_i),
        .ntt_o     (ntt_o),
        .out_valid (out_valid),
        .out_odd   (out_odd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Drives one cycle of input starting just after the rising edge.
    task automatic applyStimulus(input logic v, input coef_t d, input coef_t w, input logic st);
        @(posedge clk);
        #1;
        in_valid  = v;
        data_i    = d;
        twiddle_i = w;
        start     = st;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, '0, '0, 1'b0);
    endtask

    task automatic applyPair(input coef_t a, input coef_t b, input coef_t w, input coef_t even,
                             input coef_t odd, input logic st, input logic push);
        applyStimulus(1'b1, a, '0, st);
        applyStimulus(1'b1, b, w, 1'b0);
        k_last = cyc;
        if (push) begin
            sbq.push_back('{even, 1'b0, cyc + LAT + 2});
            sbq.push_back('{odd, 1'b1, cyc + LAT + 3});
        end
    endtask

    task automatic waitCycle(input int target);
        do @(negedge clk); while (cyc < target);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < 80) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", {31'd0, (sbq.size() == 0 && !busy)}, 32'd1);
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected output at cycle %0d: got %0d (odd=%0d), expected none",
                         cyc, ntt_o, out_odd);
            end else begin
                mon_e = sbq.pop_front();
                checkOutput("result value", 32'(ntt_o), 32'(mon_e.val));
                checkOutput("result slot", {31'd0, out_odd}, {31'd0, mon_e.odd});
                checkOutput("result cycle", cyc, mon_e.when);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ntt_o", 32'(ntt_o), 32'd0);
        checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset out_odd", {31'd0, out_odd}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] basic pair 5,3 w=9");
        applyPair(16'd5, 16'd3, 16'd9, 16'd4, 16'd9, 1'b0, 1'b1);
        applyIdle();
        waitDrain();
        @(negedge clk);
        checkOutput("hold out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("hold ntt_o", 32'(ntt_o), 32'd9);
        checkOutput("hold out_odd", {31'd0, out_odd}, 32'd1);

        $display("[TB] lone a then start-only pulse");
        applyStimulus(1'b1, 16'd7, '0, 1'b0);
        applyIdle();
        @(negedge clk);
        checkOutput("busy lone a", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, '0, '0, 1'b1);
        applyIdle();
        @(negedge clk);
        checkOutput("busy after start", {31'd0, busy}, 32'd0);

        $display("[TB] odd halving and borrow wrap");
        applyPair(16'd6, 16'd1, 16'd2, 16'd12, 16'd5, 1'b0, 1'b1);
        applyPair(16'd2, 16'd10, 16'd1, 16'd6, 16'd13, 1'b0, 1'b1);
        applyIdle();
        waitDrain();

        $display("[TB] continuous stream of 8 samples");
        applyPair(16'd1, 16'd2, 16'd3, 16'd10, 16'd7, 1'b0, 1'b1);
        applyPair(16'd16, 16'd16, 16'd5, 16'd16, 16'd0, 1'b0, 1'b1);
        applyPair(16'd0, 16'd0, 16'd7, 16'd0, 16'd0, 1'b0, 1'b1);
        applyPair(16'd9, 16'd3, 16'd16, 16'd6, 16'd14, 1'b0, 1'b1);
        applyIdle();
        waitCycle(k_last + LAT + 2);
        checkOutput("busy during stream", {31'd0, busy}, 32'd1);
        waitCycle(k_last + LAT + 4);
        checkOutput("busy after stream", {31'd0, busy}, 32'd0);
        checkOutput("out_valid after stream", {31'd0, out_valid}, 32'd0);
        waitDrain();

        $display("[TB] reset with pair in flight and held a");
        applyPair(16'd3, 16'd5, 16'd2, '0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'd11, '0, 1'b0);
        applyIdle();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("out_valid in reset", {31'd0, out_valid}, 32'd0);
            checkOutput("busy in reset", {31'd0, busy}, 32'd0);
        end
        reset = 1'b1;
        applyPair(16'd4, 16'd4, 16'd1, 16'd4, 16'd0, 1'b0, 1'b1);
        applyIdle();
        waitDrain();
        repeat (20) @(negedge clk);

        $display("[TB] start realigns over held a");
        applyStimulus(1'b1, 16'd7, '0, 1'b0);
        applyPair(16'd1, 16'd1, 16'd3, 16'd1, 16'd0, 1'b1, 1'b1);
        applyIdle();
        waitDrain();
        repeat (20) @(negedge clk);
        checkOutput("scoreboard empty", sbq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
